// File: rtl/obi_cache_master.sv
// obi_cache_master: serialises one {op,key,value} cache command into OBI
// write beats. The value is then either read back over OBI or taken from the
// op-word response data.
// Optional feature macro: OBI_CACHE_MASTER_READBACK_EN. When it is defined,
// the value words are read back after the writes and assembled into
// rsp_value. When it is undefined, the command completes straight after the
// op-word write, and rsp_value is that beat's rdata zero-extended.

package if_types_pkg;
  localparam int unsigned OBI_ADDR_W = 32;
  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned OBI_ID_W   = 3;

  typedef struct packed {
    logic                    req;
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
    logic [OBI_ID_W-1:0]     aid;
  } obi_req_t;

  typedef struct packed {
    logic                  gnt;
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
    logic [OBI_ID_W-1:0]   rid;
    logic                  err;
  } obi_rsp_t;
endpackage

module obi_cache_master
  import if_types_pkg::*;
#(
  parameter int unsigned ARCHITECTURE = 32,
  parameter int unsigned ID_WIDTH     = 3,
  parameter int unsigned VALUE_WIDTH  = 64,
  parameter int unsigned KEY_WIDTH    = 24,
  parameter int unsigned OP_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_WIDTH-1:0]    cmd_op,
  input  logic [KEY_WIDTH-1:0]   cmd_key,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   rsp_valid,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic                   rsp_err,
  output obi_req_t               obi_req,
  input  obi_rsp_t               obi_resp
);

  localparam int unsigned FRAME_W   = VALUE_WIDTH + KEY_WIDTH + OP_WIDTH;
  localparam int unsigned N_WR      = FRAME_W / ARCHITECTURE;
  localparam int unsigned N_RD      = VALUE_WIDTH / ARCHITECTURE;
  localparam int unsigned MAX_BEATS = (N_WR > N_RD) ? N_WR : N_RD;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e                   state_q, state_d;
  obi_req_t                 req_q, req_d;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [ID_WIDTH-1:0]      aid_q, aid_d;
  logic                     err_q, err_d;
  logic [VALUE_WIDTH-1:0]   value_q, value_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     cmd_ready_q, cmd_ready_d;
  logic                     rsp_beat;
  logic                     beat_err;
  logic [ARCHITECTURE-1:0]  rdata_a;

  // Build one single-beat OBI request with all byte lanes enabled.
  function automatic obi_req_t make_req(input logic we,
                                        input logic [BEAT_W-1:0] idx,
                                        input logic [ARCHITECTURE-1:0] wdata,
                                        input logic [ID_WIDTH-1:0] aid);
    obi_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.addr  = OBI_ADDR_W'({idx, 2'b00});
    r.we    = we;
    r.be    = '1;
    r.wdata = OBI_DATA_W'(wdata);
    r.aid   = OBI_ID_W'(aid);
    return r;
  endfunction

  // Select frame word idx; the value occupies the low words and the op the top.
  function automatic logic [ARCHITECTURE-1:0] frame_word(input logic [FRAME_W-1:0] f,
                                                         input logic [BEAT_W-1:0] idx);
    return ARCHITECTURE'(f >> (32'(idx) * ARCHITECTURE));
  endfunction

  // Next-state, next-request and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    frame_d     = frame_q;
    beat_d      = beat_q;
    aid_d       = aid_q;
    err_d       = err_q;
    value_d     = value_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    cmd_ready_d = 1'b0;
    rsp_beat    = 1'b0;
    rdata_a     = ARCHITECTURE'(obi_resp.rdata);
    beat_err    = obi_resp.err | (ID_WIDTH'(obi_resp.rid) != ID_WIDTH'(req_q.aid));

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          frame_d   = {cmd_op, cmd_key, cmd_value};
          beat_d    = '0;
          value_d   = '0;
          rsp_err_d = 1'b0;
          err_d     = 1'b0;
          if (cmd_op == '0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = make_req(1'b1, '0, frame_word({cmd_op, cmd_key, cmd_value}, '0), aid_q);
            aid_d   = aid_q + ID_WIDTH'(1);
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ, RD_REQ: begin
        if (obi_resp.gnt) begin
          req_d.req = 1'b0;
          if (obi_resp.rvalid) begin
            rsp_beat = 1'b1;
          end else begin
            state_d = (state_q == WR_REQ) ? WR_RSP : RD_RSP;
          end
        end
      end
      WR_RSP, RD_RSP: begin
        if (obi_resp.rvalid) begin
          rsp_beat = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase

    // A completed beat either issues the next beat or finishes the command.
    if (rsp_beat) begin
      err_d = err_q | beat_err;
      if (req_q.we) begin
        if (beat_q < BEAT_W'(N_WR - 1)) begin
          beat_d  = beat_q + BEAT_W'(1);
          req_d   = make_req(1'b1, beat_d, frame_word(frame_q, beat_d), aid_q);
          aid_d   = aid_q + ID_WIDTH'(1);
          state_d = WR_REQ;
        end else begin
`ifdef OBI_CACHE_MASTER_READBACK_EN
          beat_d  = '0;
          req_d   = make_req(1'b0, '0, '0, aid_q);
          aid_d   = aid_q + ID_WIDTH'(1);
          state_d = RD_REQ;
`else
          value_d = VALUE_WIDTH'(rdata_a);
          state_d = DONE;
`endif
        end
      end else begin
        value_d[32'(beat_q) * ARCHITECTURE +: ARCHITECTURE] = rdata_a;
        if (beat_q < BEAT_W'(N_RD - 1)) begin
          beat_d  = beat_q + BEAT_W'(1);
          req_d   = make_req(1'b0, beat_d, '0, aid_q);
          aid_d   = aid_q + ID_WIDTH'(1);
          state_d = RD_REQ;
        end else begin
          state_d = DONE;
        end
      end
    end

    if (state_d == DONE) begin
      rsp_err_d   = err_d;
      rsp_valid_d = 1'b1;
    end
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      frame_q     <= '0;
      beat_q      <= '0;
      aid_q       <= '0;
      err_q       <= 1'b0;
      value_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      frame_q     <= frame_d;
      beat_q      <= beat_d;
      aid_q       <= aid_d;
      err_q       <= err_d;
      value_q     <= value_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign obi_req   = req_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_value = value_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_obi_cache_master.sv
// Testbench for obi_cache_master: a randomised OBI slave plus a
// transaction-level model of the expected beats, ids and results.
module tb_obi_cache_master;
  import if_types_pkg::*;

  localparam int unsigned N_WR = 3;
  localparam int unsigned N_RD = 2;
`ifdef OBI_CACHE_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [23:0] cmd_key;
  logic [63:0] cmd_value;
  logic        rsp_valid;
  logic [63:0] rsp_value;
  logic        rsp_err;
  obi_req_t    obi_req;
  obi_rsp_t    obi_resp;

  obi_cache_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_err(rsp_err),
    .obi_req(obi_req), .obi_resp(obi_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  // Slave configuration.
  int unsigned gnt_min, gnt_max, rsp_min, rsp_max, err_pct, badrid_pct;
  int          first_gnt_wait = -1;
  bit          err_on_opword = 1'b0;
  bit          bad_rid_dir = 1'b0;
  bit          use_rd_tab = 1'b0;
  logic [31:0] rd_tab [2];

  // Slave state and reference accumulators.
  txn_t        txq[$];
  txn_t        cur;
  bit          pending = 1'b0;
  bit          hold_valid = 1'b0;
  int          gnt_wait = -1;
  int          resp_wait = 0;
  obi_req_t    held;
  logic [63:0] acc_value;
  bit          acc_err;
  logic [2:0]  aid_model = 3'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int unsigned gmin, input int unsigned gmax,
                         input int unsigned rmin, input int unsigned rmax,
                         input int unsigned ep, input int unsigned rp);
    gnt_min = gmin; gnt_max = gmax; rsp_min = rmin; rsp_max = rmax;
    err_pct = ep; badrid_pct = rp;
    err_on_opword = 1'b0; bad_rid_dir = 1'b0; use_rd_tab = 1'b0; first_gnt_wait = -1;
  endtask

  // Drive one response beat and fold it into the expected result.
  task automatic respond(input txn_t t);
    logic [31:0] rdata;
    bit          e, bad;
    int          idx;
    rdata = $urandom;
    if (use_rd_tab && !t.we) rdata = rd_tab[t.addr[2]];
    e   = (err_on_opword && t.we && t.addr == 32'(4 * (N_WR - 1))) ||
          ($urandom_range(99, 0) < err_pct);
    bad = (bad_rid_dir && (t.we != RB) && t.addr == (RB ? 32'd4 : 32'd8)) ||
          ($urandom_range(99, 0) < badrid_pct);
    obi_resp.rvalid = 1'b1;
    obi_resp.rdata  = rdata;
    obi_resp.err    = e;
    obi_resp.rid    = bad ? t.aid + 3'd1 : t.aid;
    acc_err = acc_err | e | bad;
    idx = t.addr[2] ? 32 : 0;
    if (!t.we) acc_value[idx +: 32] = rdata;
    else if (!RB && t.addr == 32'(4 * (N_WR - 1))) acc_value = {32'h0, rdata};
  endtask

  // One slave cycle, evaluated mid-cycle so the master samples it on the next edge.
  task automatic slave_step();
    obi_resp = '0;
    if (!rst_n) begin
      pending = 1'b0; hold_valid = 1'b0; gnt_wait = -1;
      return;
    end
    if (pending) begin
      if (resp_wait == 0) begin
        respond(cur);
        pending = 1'b0;
      end else begin
        resp_wait--;
      end
    end else if (obi_req.req) begin
      if (gnt_wait < 0) begin
        gnt_wait = (first_gnt_wait >= 0) ? first_gnt_wait : int'($urandom_range(gnt_max, gnt_min));
        first_gnt_wait = -1;
      end
      if (hold_valid) check("req_hold", 64'(obi_req == held), 64'd1);
      if (gnt_wait == 0) begin
        obi_resp.gnt = 1'b1;
        cur.addr = obi_req.addr; cur.we = obi_req.we; cur.be = obi_req.be;
        cur.wdata = obi_req.wdata; cur.aid = obi_req.aid;
        txq.push_back(cur);
        hold_valid = 1'b0;
        gnt_wait = -1;
        resp_wait = int'($urandom_range(rsp_max, rsp_min));
        if (resp_wait == 0) respond(cur);
        else begin
          pending = 1'b1;
          resp_wait--;
        end
      end else begin
        gnt_wait--;
        held = obi_req;
        hold_valid = 1'b1;
      end
    end
  endtask

  initial begin
    obi_resp = '0;
    forever begin
      @(negedge clk);
      slave_step();
    end
  end

  // Issue one command, wait for completion, compare result and bus beats.
  task automatic run_cmd(input logic [7:0] op, input logic [23:0] key,
                         input logic [63:0] value, output int lat);
    logic [95:0] frame;
    logic [63:0] v_hold;
    logic        e_hold;
    int          n_exp;
    bit          wr;
    int          k;
    frame = {op, key, value};
    acc_value = 64'h0;
    acc_err = (op == 8'h0);
    txq.delete();
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = value;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat >= 2000) begin
        check("rsp_timeout", 64'd0, 64'd1);
        return;
      end
    end
    check("rsp_value", rsp_value, acc_value);
    check("rsp_err", 64'(rsp_err), 64'(acc_err));
    n_exp = (op == 8'h0) ? 0 : int'(N_WR + (RB ? N_RD : 0));
    check("txn_count", 64'(txq.size()), 64'(n_exp));
    for (int i = 0; i < txq.size(); i++) begin
      wr = (i < int'(N_WR));
      k  = wr ? i : i - int'(N_WR);
      check("txn_addr", 64'(txq[i].addr), 64'(4 * k));
      check("txn_we", 64'(txq[i].we), 64'(wr));
      check("txn_be", 64'(txq[i].be), 64'hF);
      if (wr) check("txn_wdata", 64'(txq[i].wdata), 64'(frame[32*k +: 32]));
      check("txn_aid", 64'(txq[i].aid), 64'(aid_model));
      aid_model = aid_model + 3'd1;
    end
    v_hold = rsp_value;
    e_hold = rsp_err;
    @(negedge clk);
    check("rsp_pulse_1cyc", 64'(rsp_valid), 64'd0);
    check("rsp_value_hold", rsp_value, v_hold);
    check("rsp_err_hold", 64'(rsp_err), 64'(e_hold));
    check("cmd_ready_after", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int cyc;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0;
    set_cfg(0, 0, 1, 1, 0, 0);
    #12;
    check("rst_obi_req", 64'(obi_req == '0), 64'd1);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_value", rsp_value, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Gnt tied high, rvalid one cycle after gnt: minimum latency.
    set_cfg(0, 0, 1, 1, 0, 0);
    run_cmd(8'h01, 24'h00ABCD, 64'h1122334455667788, lat);
    check("latency_min", 64'(lat), RB ? 64'd11 : 64'd7);

    // Grant withheld five cycles on the first beat.
    set_cfg(0, 0, 1, 1, 0, 0);
    first_gnt_wait = 5;
    run_cmd(8'h02, 24'h123456, 64'hCAFEF00D_01234567, lat);

    // NOOP completes immediately with error and no bus traffic.
    set_cfg(0, 0, 1, 1, 0, 0);
    run_cmd(8'h00, 24'h000001, 64'h55, lat);
    check("noop_latency", 64'(lat), 64'd1);
    check("noop_err", 64'(rsp_err), 64'd1);

    // Error on the op-word response, fixed read-back data.
    set_cfg(0, 1, 0, 2, 0, 0);
    err_on_opword = 1'b1;
    use_rd_tab = 1'b1;
    rd_tab[0] = 32'hDEADBEEF;
    rd_tab[1] = 32'h0BADF00D;
    run_cmd(8'h03, 24'h0F0F0F, 64'h0, lat);
    check("opword_err", 64'(rsp_err), 64'd1);
    check("readback_value", rsp_value, RB ? 64'h0BADF00DDEADBEEF : acc_value);

    // Response id mismatch on a single beat.
    set_cfg(0, 0, 1, 1, 0, 0);
    bad_rid_dir = 1'b1;
    run_cmd(8'h04, 24'hABCDEF, 64'h1, lat);
    check("rid_err", 64'(rsp_err), 64'd1);
    set_cfg(0, 0, 1, 1, 0, 0);
    run_cmd(8'h05, 24'h000002, 64'h2, lat);
    check("rid_err_cleared", 64'(rsp_err), 64'd0);

    // Reset while waiting on the first write response.
    set_cfg(0, 0, 4, 4, 0, 0);
    txq.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 8'h06; cmd_key = 24'h1; cmd_value = 64'h9;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (txq.size() == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_granted", 64'(txq.size()), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req", 64'(obi_req.req), 64'd0);
    check("abort_idle", 64'(cmd_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aid_model = 3'd0;
    set_cfg(0, 0, 1, 1, 0, 0);
    run_cmd(8'h07, 24'h777777, 64'h7777777788888888, lat);

    // Randomised commands and slave timing.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] rop;
      set_cfg(0, 3, 0, 3, 10, 10);
      rop = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom);
      run_cmd(rop, 24'($urandom), {32'($urandom), 32'($urandom)}, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
